// File: rtl/ul4_seq.sv
// ul4_seq: repeat-step sequencer around the 4-bit ul4 logic unit.
// Loads RA/RB, applies one op N times, reports via done/ack.
module ul4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] s,
  output logic [3:0] out
);

  always_comb begin
    out = a;
    unique case (s)
      2'b00: out = a;
      2'b01: out = b;
      2'b10: out = a + 4'd1;
      2'b11: out = b + 4'd1;
      default: out = a;
    endcase
  end

endmodule

module ul4_seq #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       a_in,
  input  logic [3:0]       b_in,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_t           state;
  state_t           state_nx;
  logic [3:0]       ra;
  logic [3:0]       rb;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt;
  logic             wrap_r;
  logic [3:0]       alu_out;
  logic [3:0]       src;

  ul4 u_ul4 (
    .a   (ra),
    .b   (rb),
    .s   (op_r),
    .out (alu_out)
  );

  assign src = op_r[0] ? rb : ra;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (count != '0) ? RUN : DONE;
      end
      RUN: begin
        if (cnt == ONE) state_nx = DONE;
      end
      DONE: begin
        if (ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath registers; only the op_r[0]-selected one is written in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra     <= '0;
      rb     <= '0;
      op_r   <= '0;
      cnt    <= '0;
      wrap_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ra     <= a_in;
            rb     <= b_in;
            op_r   <= op;
            cnt    <= count;
            wrap_r <= 1'b0;
          end
        end
        RUN: begin
          if (op_r[0]) rb <= alu_out;
          else         ra <= alu_out;
          if (op_r[1] && src == 4'hF)
            wrap_r <= 1'b1;
          cnt <= cnt - ONE;
        end
        default: begin
        end
      endcase
    end
  end

  assign result = src;
  assign wrap   = wrap_r;

endmodule

// File: doc/ul4_seq.md
Name: ul4_seq

Overview:
Sequencer for the 4-bit logic unit ul4 (S=00 pass A, 01 pass B, 10 A+1, 11 B+1).
- Loads two operand registers and applies one selected operation N times, writing each result back into its source register.
- Reports the final value through a start/done/ack handshake.
- Sits between a host (test harness or upper-level control) and one ul4 instance, which it instantiates and drives.

Parameters:
CNT_W, 4, width of the repeat-count input and internal down-counter (N max = 2^CNT_W - 1)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  command request; sampled only in IDLE
a_in  input  4  initial value for operand register RA
b_in  input  4  initial value for operand register RB
op  input  2  ul4 select code applied on every step
count  input  CNT_W  number of steps N
ack  input  1  host acknowledge of result; sampled only in DONE
busy  output  1  high in RUN
done  output  1  high in DONE
result  output  4  selected register: RA if op_r[0]=0, RB if op_r[0]=1
wrap  output  1  sticky: an increment step rolled F->0 during current command

Behaviour:
- Reset:
  - State IDLE.
  - RA=RB=0, op_r=00, cnt=0, wrap=0.
  - Outputs: busy=0, done=0, result=0, wrap=0.
  - Asynchronous: takes effect without a clock edge, including mid-RUN or mid-DONE. The command in progress is lost.
- Internal registers: RA, RB (4b), op_r (2b), cnt (CNT_W), wrap (1b).
- ul4 drive: A=RA, B=RB, S=op_r, combinationally. The sequencer adds no logic on the datapath.
- State IDLE:
  - On start=1: RA<=a_in, RB<=b_in, op_r<=op, cnt<=count, wrap<=0.
  - Next state is RUN if count!=0, otherwise DONE.
  - start=0 holds all registers.
- State RUN (busy=1), one step per cycle:
  - If op_r[0]=0: RA<=ul4.Out, RB holds.
  - If op_r[0]=1: RB<=ul4.Out, RA holds.
  - op_r=00/01 are hold steps (value unchanged); op_r=10/11 increment mod 16.
  - wrap<=1 when op_r[1]=1 and the source register = 4'hF at the step.
  - cnt<=cnt-1. On the step where cnt==1, next state is DONE.
- State DONE (done=1):
  - RA, RB, wrap, op_r hold; result is stable.
  - ack=1 moves to IDLE next edge; done deasserts that edge.
  - result and wrap keep their values in IDLE until the next accepted start.
- Latency: start accepted at edge k.
  - RUN occupies edges k+1..k+N; done=1 from edge k+N (after the last RUN edge) until ack.
  - Equivalently, done is first visible N+1 cycles after the start cycle.
  - N=0: done=1 from edge k+1, result = loaded operand.
- Boundaries:
  - start outside IDLE is ignored: no reload, no queueing.
  - ack outside DONE is ignored.
  - start and ack both high in DONE: ack honoured, start ignored. Host must re-assert start in IDLE.
  - start held continuously: a new command is accepted on every IDLE cycle, one idle cycle minimum between commands.
  - cnt never underflows: RUN is never entered with cnt=0.
  - count = 2^CNT_W-1 (15) must complete without counter wrap.
- busy and done are mutually exclusive; both 0 in IDLE.

Test Plan:
- Increment A: reset, then start with a_in=3, b_in=9, op=10, count=4.
  - Required: busy high 4 cycles; done=1 on 5th cycle after start; result=7; wrap=0; RB unchanged at 9.
- Increment B with wrap: a_in=0, b_in=E, op=11, count=3.
  - Required: result=1; wrap=1; done held until ack, then done=0 next cycle and state IDLE.
- Hold ops: op=00, a_in=5, count=7 -> result=5, wrap=0. Then op=01, b_in=C, count=2 -> result=C.
- Zero count: op=10, a_in=A, count=0 -> done=1 one cycle after start, busy never high, result=A.
- Handshake protection: pulse start with new operands during RUN -> ignored, original command completes with its own result. In DONE drive start=1 and ack=1 together -> returns to IDLE, no new command. Start again one cycle later -> accepted.
- Reset mid-operation: op=10, count=15, reset asserted asynchronously between edges during RUN.
  - Required: busy/done/result/wrap=0 immediately.
  - After release, start a_in=1 count=15 -> result=0 (1+15 mod 16), wrap=1.
